// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour width, pixel and
// timing-flag layouts, and total-period helpers.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 4;

  // Field order matches the renderer bus: {b,g,r}, r in the low bits.
  typedef struct packed {
    logic [DEF_COLOR_W-1:0] b;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] r;
  } pixel_t;

  typedef struct packed {
    logic frame_start;
    logic line_start;
    logic v_sync;
    logic h_sync;
    logic active;
  } timing_flags_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that carries timing flags alongside the renderer
// latency so they line up with returned pixel data.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_25_175,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // NOTE: these stages are plain flops rather than a RAM, so every stage is
  // cleared on reset; a stale sync or data-enable flag must never reach the pins.
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, early pixel requests to the
// renderer, latency-matched sync/DE pipeline and registered DAC outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int RES_SHIFT   = 0,
  parameter int PIX_LATENCY = 2
) (
  input  logic                 clk_25_175,
  input  logic                 reset,
  output logic [10:0]          req_x,
  output logic [9:0]           req_y,
  output logic                 req_valid,
  input  logic [3*COLOR_W-1:0] pix_data,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 de,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int FLAGS_W = $bits(timing_flags_t);

  logic [10:0]        r_h_cnt;
  logic [9:0]         r_v_cnt;
  timing_flags_t      w_flags;
  timing_flags_t      w_flags_dly;
  logic [FLAGS_W-1:0] w_flags_dly_bits;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic               r_line_start;
  logic               r_frame_start;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_grn;
  logic [COLOR_W-1:0] r_blu;

  // NOTE: reset is synchronous; it is sampled on the clock edge only and so
  // stays out of the sensitivity list.
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  always_comb begin
    w_flags             = '0;
    w_flags.active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_flags.h_sync      = (r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E);
    w_flags.v_sync      = (r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E);
    w_flags.line_start  = (r_h_cnt == '0) && (r_v_cnt < V_ACT);
    w_flags.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  assign req_valid = w_flags.active;
  assign req_x     = r_h_cnt >> RES_SHIFT;
  assign req_y     = r_v_cnt >> RES_SHIFT;

  vga_delay_line #(
    .WIDTH (FLAGS_W),
    .DEPTH (PIX_LATENCY)
  ) u_flag_dly (
    .clk_25_175 (clk_25_175),
    .reset      (reset),
    .i_data     (w_flags),
    .o_data     (w_flags_dly_bits)
  );

  assign w_flags_dly = timing_flags_t'(w_flags_dly_bits);

  // Sync flags are active-true internally; polarity is applied at the pins.
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_red         <= '0;
      r_grn         <= '0;
      r_blu         <= '0;
    end else begin
      r_hsync       <= w_flags_dly.h_sync ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_flags_dly.v_sync ? VSYNC_POL : ~VSYNC_POL;
      r_de          <= w_flags_dly.active;
      r_line_start  <= w_flags_dly.line_start;
      r_frame_start <= w_flags_dly.frame_start;
      r_red         <= w_flags_dly.active ? pix_data[COLOR_W-1:0]             : '0;
      r_grn         <= w_flags_dly.active ? pix_data[2*COLOR_W-1:COLOR_W]     : '0;
      r_blu         <= w_flags_dly.active ? pix_data[3*COLOR_W-1:2*COLOR_W]   : '0;
    end
  end

  assign h_sync      = r_hsync;
  assign v_sync      = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign r           = r_red;
  assign g           = r_grn;
  assign b           = r_blu;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: four configurations run side by side
// against a bench renderer and a queue-based scoreboard of expected pin values.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    int   ha, hfp, hs, hbp, va, vfp, vs, vbp, pl, rs;
    logic hpol, vpol;
  } cfg_t;

  localparam int N_DUT = 4;
  localparam int SM_HA = 32, SM_HFP = 4, SM_HS = 8, SM_HBP = 6;
  localparam int SM_VA = 24, SM_VFP = 3, SM_VS = 2, SM_VBP = 4;
  localparam int PL_A = 2, PL_B = 1, PL_C = 8, PL_D = 3;
  localparam int SEL_DE = 0, SEL_HS = 1, SEL_VS = 2, SEL_FS = 3, SEL_RV = 4;

  logic        clk_25_175 = 1'b0;
  logic        reset      = 1'b0;
  logic [10:0] req_x       [N_DUT];
  logic [9:0]  req_y       [N_DUT];
  logic        req_valid   [N_DUT];
  logic [11:0] pix_data    [N_DUT];
  logic        h_sync      [N_DUT];
  logic        v_sync      [N_DUT];
  logic        de          [N_DUT];
  logic        line_start  [N_DUT];
  logic        frame_start [N_DUT];
  logic [3:0]  r           [N_DUT];
  logic [3:0]  g           [N_DUT];
  logic [3:0]  b           [N_DUT];

  logic [20:0] hist [N_DUT][8];
  logic [16:0] exp_q [N_DUT][$];

  int n_tests = 0;
  int n_fail  = 0;

  always #20 clk_25_175 = ~clk_25_175;

  function automatic cfg_t cfg(input int id);
    cfg_t c;
    c = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33,
          pl: PL_A, rs: 0, hpol: 1'b0, vpol: 1'b0};
    case (id)
      1: c = '{ha: SM_HA, hfp: SM_HFP, hs: SM_HS, hbp: SM_HBP, va: SM_VA, vfp: SM_VFP,
               vs: SM_VS, vbp: SM_VBP, pl: PL_B, rs: 0, hpol: 1'b0, vpol: 1'b0};
      2: c = '{ha: SM_HA, hfp: SM_HFP, hs: SM_HS, hbp: SM_HBP, va: SM_VA, vfp: SM_VFP,
               vs: SM_VS, vbp: SM_VBP, pl: PL_C, rs: 0, hpol: 1'b1, vpol: 1'b1};
      3: begin c.pl = PL_D; c.rs = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Renderer contract: {b,g,r} = {x[3:0], y[3:0], x[7:4]}.
  function automatic logic [11:0] render(input logic [20:0] req);
    logic [10:0] x;
    logic [9:0]  y;
    pixel_t      p;
    x = req[20:10];
    y = req[9:0];
    p.b = x[3:0];
    p.g = y[3:0];
    p.r = x[7:4];
    return p;
  endfunction

  always @(posedge clk_25_175) begin
    for (int id = 0; id < N_DUT; id++) begin
      hist[id][0] <= {req_x[id], req_y[id]};
      for (int i = 1; i < 8; i++) hist[id][i] <= hist[id][i-1];
    end
  end

  always_comb begin
    for (int id = 0; id < N_DUT; id++) pix_data[id] = render(hist[id][cfg(id).pl-1]);
  end

  vga_timing_gen #(.PIX_LATENCY(PL_A)) u_dut_a (
    .clk_25_175(clk_25_175), .reset(reset), .req_x(req_x[0]), .req_y(req_y[0]),
    .req_valid(req_valid[0]), .pix_data(pix_data[0]), .h_sync(h_sync[0]), .v_sync(v_sync[0]),
    .r(r[0]), .g(g[0]), .b(b[0]), .de(de[0]), .line_start(line_start[0]),
    .frame_start(frame_start[0]));

  vga_timing_gen #(.H_ACTIVE(SM_HA), .H_FP(SM_HFP), .H_SYNC(SM_HS), .H_BP(SM_HBP),
    .V_ACTIVE(SM_VA), .V_FP(SM_VFP), .V_SYNC(SM_VS), .V_BP(SM_VBP),
    .PIX_LATENCY(PL_B)) u_dut_b (
    .clk_25_175(clk_25_175), .reset(reset), .req_x(req_x[1]), .req_y(req_y[1]),
    .req_valid(req_valid[1]), .pix_data(pix_data[1]), .h_sync(h_sync[1]), .v_sync(v_sync[1]),
    .r(r[1]), .g(g[1]), .b(b[1]), .de(de[1]), .line_start(line_start[1]),
    .frame_start(frame_start[1]));

  vga_timing_gen #(.H_ACTIVE(SM_HA), .H_FP(SM_HFP), .H_SYNC(SM_HS), .H_BP(SM_HBP),
    .V_ACTIVE(SM_VA), .V_FP(SM_VFP), .V_SYNC(SM_VS), .V_BP(SM_VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LATENCY(PL_C)) u_dut_c (
    .clk_25_175(clk_25_175), .reset(reset), .req_x(req_x[2]), .req_y(req_y[2]),
    .req_valid(req_valid[2]), .pix_data(pix_data[2]), .h_sync(h_sync[2]), .v_sync(v_sync[2]),
    .r(r[2]), .g(g[2]), .b(b[2]), .de(de[2]), .line_start(line_start[2]),
    .frame_start(frame_start[2]));

  vga_timing_gen #(.RES_SHIFT(1), .PIX_LATENCY(PL_D)) u_dut_d (
    .clk_25_175(clk_25_175), .reset(reset), .req_x(req_x[3]), .req_y(req_y[3]),
    .req_valid(req_valid[3]), .pix_data(pix_data[3]), .h_sync(h_sync[3]), .v_sync(v_sync[3]),
    .r(r[3]), .g(g[3]), .b(b[3]), .de(de[3]), .line_start(line_start[3]),
    .frame_start(frame_start[3]));

  function automatic logic [16:0] obs(input int id);
    return {frame_start[id], line_start[id], v_sync[id], h_sync[id], de[id], b[id], g[id], r[id]};
  endfunction

  function automatic logic [16:0] reset_obs(input int id);
    cfg_t c;
    c = cfg(id);
    return {1'b0, 1'b0, ~c.vpol, ~c.hpol, 1'b0, 12'h000};
  endfunction

  // Expected pin values produced by the counters at cycle k after reset release.
  function automatic logic [16:0] model(input int id, input int k);
    cfg_t        c;
    int          ht, vt, h, v;
    logic        act, hsf, vsf;
    logic [11:0] rgb;
    c   = cfg(id);
    ht  = c.ha + c.hfp + c.hs + c.hbp;
    vt  = c.va + c.vfp + c.vs + c.vbp;
    h   = k % ht;
    v   = (k / ht) % vt;
    act = (h < c.ha) && (v < c.va);
    hsf = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
    vsf = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
    rgb = act ? render({11'(h >> c.rs), 10'(v >> c.rs)}) : 12'h000;
    return {(h == 0) && (v == 0), (h == 0) && (v < c.va), vsf ? c.vpol : ~c.vpol,
            hsf ? c.hpol : ~c.hpol, act, rgb};
  endfunction

  function automatic logic sig(input int id, input int sel);
    case (sel)
      SEL_DE:  return de[id];
      SEL_HS:  return h_sync[id];
      SEL_VS:  return v_sync[id];
      SEL_FS:  return frame_start[id];
      SEL_RV:  return req_valid[id];
      default: return 1'b0;
    endcase
  endfunction

  // Leaves the bench on a falling edge with reset just released (cycle k=0).
  task automatic pulse_reset();
    @(negedge clk_25_175);
    reset = 1'b0;
    repeat (3) @(negedge clk_25_175);
    reset = 1'b1;
  endtask

  task automatic wait_level(input int id, input int sel, input logic lvl, input int budget,
                            output int cycles);
    cycles = 0;
    while (sig(id, sel) !== lvl && cycles < budget) begin
      @(negedge clk_25_175);
      cycles++;
    end
    if (sig(id, sel) !== lvl) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_timeout dut%0d sel%0d: level %b not seen in %0d clks", id, sel, lvl, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_25_175);
    reset = 1'b0;
    repeat (3) @(negedge clk_25_175);
    for (int id = 0; id < N_DUT; id++) begin
      n_tests++;
      if (obs(id) !== reset_obs(id)) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: got %h expected %h", id, obs(id), reset_obs(id));
      end
      n_tests++;
      if ({req_valid[id], req_x[id], req_y[id]} !== {1'b1, 21'd0}) begin
        n_fail++;
        $display("FAIL reset_request dut%0d: got v=%b x=%0d y=%0d expected v=1 x=0 y=0",
                 id, req_valid[id], req_x[id], req_y[id]);
      end
    end
  endtask

  task automatic test_scoreboard(input int ncyc);
    logic [16:0] exp_v;
    int          shown;
    shown = 0;
    for (int id = 0; id < N_DUT; id++) exp_q[id].delete();
    pulse_reset();
    for (int k = 0; k < ncyc; k++) begin
      for (int id = 0; id < N_DUT; id++) begin
        exp_q[id].push_back(model(id, k));
        if (exp_q[id].size() > cfg(id).pl + 1) exp_v = exp_q[id].pop_front();
        else exp_v = reset_obs(id);
        n_tests++;
        if (obs(id) !== exp_v) begin
          n_fail++;
          if (shown < 20) begin
            shown++;
            $display("FAIL pixel_pipe dut%0d cycle %0d: got %h expected %h", id, k, obs(id), exp_v);
          end
        end
      end
      @(negedge clk_25_175);
    end
  endtask

  task automatic test_frame_counts(input int id);
    int n_fs, n_ls, n_de;
    n_fs = 0; n_ls = 0; n_de = 0;
    pulse_reset();
    for (int k = 0; k < (SM_HA + SM_HFP + SM_HS + SM_HBP) * (SM_VA + SM_VFP + SM_VS + SM_VBP); k++) begin
      n_fs += int'(frame_start[id]);
      n_ls += int'(line_start[id]);
      n_de += int'(de[id]);
      @(negedge clk_25_175);
    end
    n_tests++;
    if (n_fs !== 1) begin
      n_fail++;
      $display("FAIL frame_start_count dut%0d: got %0d expected 1", id, n_fs);
    end
    n_tests++;
    if (n_ls !== SM_VA) begin
      n_fail++;
      $display("FAIL line_start_count dut%0d: got %0d expected %0d", id, n_ls, SM_VA);
    end
    n_tests++;
    if (n_de !== SM_HA * SM_VA) begin
      n_fail++;
      $display("FAIL de_count dut%0d: got %0d expected %0d", id, n_de, SM_HA * SM_VA);
    end
  endtask

  task automatic test_hsync();
    int t;
    pulse_reset();
    wait_level(0, SEL_DE, 1'b1, 50, t);
    n_tests++;
    if (t !== PL_A + 1) begin
      n_fail++;
      $display("FAIL first_de_latency: got %0d expected %0d", t, PL_A + 1);
    end
    wait_level(0, SEL_HS, 1'b0, 1000, t);
    n_tests++;
    if (t !== 656) begin
      n_fail++;
      $display("FAIL hsync_offset: got %0d expected 656", t);
    end
    wait_level(0, SEL_HS, 1'b1, 200, t);
    n_tests++;
    if (t !== 96) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d expected 96", t);
    end
  endtask

  task automatic test_vsync();
    int t;
    pulse_reset();
    wait_level(1, SEL_DE, 1'b1, 50, t);
    wait_level(1, SEL_VS, 1'b0, 3000, t);
    n_tests++;
    if (t !== (SM_VA + SM_VFP) * 50) begin
      n_fail++;
      $display("FAIL vsync_offset: got %0d expected %0d", t, (SM_VA + SM_VFP) * 50);
    end
    wait_level(1, SEL_VS, 1'b1, 500, t);
    n_tests++;
    if (t !== SM_VS * 50) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d expected %0d", t, SM_VS * 50);
    end
  endtask

  task automatic test_polarity();
    int t, total;
    pulse_reset();
    wait_level(2, SEL_DE, 1'b1, 50, t);
    total = t;
    n_tests++;
    if ({h_sync[2], v_sync[2]} !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_idle_pol: got hs=%b vs=%b expected hs=0 vs=0", h_sync[2], v_sync[2]);
    end
    wait_level(2, SEL_HS, 1'b1, 200, t);
    total += t;
    n_tests++;
    if (t !== SM_HA + SM_HFP) begin
      n_fail++;
      $display("FAIL hsync_rise_pol: got %0d expected %0d", t, SM_HA + SM_HFP);
    end
    wait_level(2, SEL_HS, 1'b0, 200, t);
    total += t;
    n_tests++;
    if (t !== SM_HS) begin
      n_fail++;
      $display("FAIL hsync_width_pol: got %0d expected %0d", t, SM_HS);
    end
    wait_level(2, SEL_VS, 1'b1, 3000, t);
    total += t;
    n_tests++;
    if (total !== (SM_VA + SM_VFP) * 50 + PL_C + 1) begin
      n_fail++;
      $display("FAIL vsync_rise_pol: got %0d expected %0d", total, (SM_VA + SM_VFP) * 50 + PL_C + 1);
    end
    wait_level(2, SEL_VS, 1'b0, 500, t);
    n_tests++;
    if (t !== SM_VS * 50) begin
      n_fail++;
      $display("FAIL vsync_width_pol: got %0d expected %0d", t, SM_VS * 50);
    end
  endtask

  task automatic test_de_latency(input int id);
    int t;
    pulse_reset();
    wait_level(id, SEL_RV, 1'b0, 200, t);
    wait_level(id, SEL_RV, 1'b1, 200, t);
    wait_level(id, SEL_DE, 1'b1, 50, t);
    n_tests++;
    if (t !== cfg(id).pl + 1) begin
      n_fail++;
      $display("FAIL de_after_req dut%0d: got %0d expected %0d", id, t, cfg(id).pl + 1);
    end
  endtask

  task automatic test_res_shift();
    int idx, line, maxx, shown;
    idx = 0; line = 0; maxx = 0; shown = 0;
    pulse_reset();
    for (int k = 0; k < 4 * 800; k++) begin
      if (req_valid[3]) begin
        n_tests++;
        if (req_x[3] !== 11'(idx / 2) || req_y[3] !== 10'(line / 2)) begin
          n_fail++;
          if (shown < 10) begin
            shown++;
            $display("FAIL res_shift_req line %0d idx %0d: got x=%0d y=%0d expected x=%0d y=%0d",
                     line, idx, req_x[3], req_y[3], idx / 2, line / 2);
          end
        end
        if (int'(req_x[3]) > maxx) maxx = int'(req_x[3]);
        idx++;
      end else if (idx != 0) begin
        n_tests++;
        if (idx !== 640 || maxx !== 319) begin
          n_fail++;
          $display("FAIL res_shift_line %0d: got count=%0d max=%0d expected count=640 max=319",
                   line, idx, maxx);
        end
        idx = 0;
        maxx = 0;
        line++;
      end
      @(negedge clk_25_175);
    end
  endtask

  task automatic test_midline_reset();
    int t;
    pulse_reset();
    repeat (10 * 50 + 20) @(negedge clk_25_175);
    n_tests++;
    if (de[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_pre_de: got %b expected 1", de[1]);
    end
    reset = 1'b0;
    @(posedge clk_25_175);
    #1;
    for (int id = 0; id < N_DUT; id++) begin
      n_tests++;
      if (obs(id) !== reset_obs(id)) begin
        n_fail++;
        $display("FAIL midline_reset dut%0d: got %h expected %h", id, obs(id), reset_obs(id));
      end
    end
    repeat (2) @(negedge clk_25_175);
    reset = 1'b1;
    wait_level(1, SEL_FS, 1'b1, 20, t);
    n_tests++;
    if (t !== PL_B + 1 || de[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_restart: got fs after %0d de=%b expected %0d de=1", t, de[1], PL_B + 1);
    end
  endtask

  initial begin
    test_reset();
    test_scoreboard(2500);
    test_frame_counts(1);
    test_frame_counts(2);
    test_hsync();
    test_vsync();
    test_polarity();
    test_de_latency(1);
    test_de_latency(2);
    test_res_shift();
    test_midline_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: bench still running after 5 ms");
    $fatal(1, "timeout");
  end

endmodule
